// File: rtl/snake_pkg.sv
// Shared snake-game definitions: heading encoding, key bit mapping and turn rules.
// Also used by the body/movement logic and the display.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_DOWN  = 2;
  localparam int KEY_LEFT  = 3;

  // Opposite heading differs only in the upper bit of the encoding
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

  function automatic logic key_any(input logic [3:0] k);
    return |k;
  endfunction

  // Lowest set key bit wins: UP > RIGHT > DOWN > LEFT
  function automatic logic [1:0] key_sel(input logic [3:0] k);
    logic [1:0] d;
    d = DIR_LEFT;
    if (k[KEY_DOWN])  d = DIR_DOWN;
    if (k[KEY_RIGHT]) d = DIR_RIGHT;
    if (k[KEY_UP])    d = DIR_UP;
    return d;
  endfunction

  function automatic logic turn_illegal(input logic [1:0] key_d, input logic [1:0] ref_d);
    return (key_d == ref_d) || (key_d == dir_opposite(ref_d));
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of 2-bit headings with head/tail visibility and sync flush.
// A push on a full FIFO is only taken when a pop frees the slot in the same cycle.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [1:0]    i_data,
  input  logic          i_pop,
  output logic [1:0]    o_head,
  output logic [1:0]    o_tail,
  output logic [CW-1:0] o_count
);

  localparam int PW = CW - 1;

  logic [1:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DIR_UP;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DIR_UP;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_tail  = r_mem[r_wr_ptr - 1'b1];
  assign o_count = r_count;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Turns debounced key pulses into the snake heading: filters illegal turns,
// queues accepted turns and releases one per game tick.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         QDEPTH   = 2,
  parameter int         CW       = 2,
  parameter logic [1:0] INIT_DIR = 2'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_pulse,
  input  logic          tick,
  input  logic          clr,
  output logic [1:0]    dir,
  output logic          step,
  output logic [CW-1:0] q_count,
  output logic          drop
);

  logic [1:0]    r_dir;
  logic          r_step;
  logic          r_drop;

  logic [1:0]    w_head;
  logic [1:0]    w_tail;
  logic [CW-1:0] w_count;
  logic          w_q_empty;
  logic          w_q_full;
  logic          w_key_vld;
  logic [1:0]    w_key_dir;
  logic [1:0]    w_ref_dir;
  logic          w_illegal;
  logic          w_push;
  logic          w_pop;
  logic          w_reject;

  assign w_q_empty = (w_count == '0);
  assign w_q_full  = (w_count == CW'(QDEPTH));
  assign w_key_vld = key_any(key_pulse);
  assign w_key_dir = key_sel(key_pulse);

  // Filter against the newest pending turn so double-taps chain correctly
  assign w_ref_dir = w_q_empty ? r_dir : w_tail;
  assign w_illegal = turn_illegal(w_key_dir, w_ref_dir);

  assign w_reject = w_key_vld && (w_illegal || (w_q_full && !tick));
  assign w_push   = !clr && w_key_vld && !w_reject;
  assign w_pop    = !clr && tick && !w_q_empty;

  dir_fifo #(
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_dir_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (clr),
    .i_push  (w_push),
    .i_data  (w_key_dir),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dir  <= INIT_DIR;
      r_step <= 1'b0;
      r_drop <= 1'b0;
    end else if (clr) begin
      r_dir  <= INIT_DIR;
      r_step <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_pop) r_dir <= w_head;
      r_step <= tick;
      r_drop <= w_reject;
    end
  end

  assign dir     = r_dir;
  assign step    = r_step;
  assign q_count = w_count;
  assign drop    = r_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl: directed scenarios plus randomized
// traffic against a queue-based heading model.
module tb_snake_dir_ctrl;

  localparam int         QDEPTH   = 2;
  localparam int         CW       = 2;
  localparam logic [1:0] INIT_DIR = 2'd1;

  logic          clk;
  logic          rst;
  logic [3:0]    key_pulse;
  logic          tick;
  logic          clr;
  logic [1:0]    dir;
  logic          step;
  logic [CW-1:0] q_count;
  logic          drop;

  int n_cmp;
  int n_bad;

  logic [1:0] m_dir;
  logic       m_step;
  logic       m_drop;
  logic [1:0] m_q[$];

  snake_dir_ctrl #(.QDEPTH(QDEPTH), .CW(CW), .INIT_DIR(INIT_DIR)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_pulse (key_pulse),
    .tick      (tick),
    .clr       (clr),
    .dir       (dir),
    .step      (step),
    .q_count   (q_count),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of one clock edge, written straight from the turn rules
  task automatic model_step(input logic [3:0] k, input logic t, input logic c);
    logic [1:0] kd;
    logic [1:0] rd;
    bit         push;
    push   = 0;
    m_drop = 0;
    if (c) begin
      m_dir  = INIT_DIR;
      m_step = 0;
      m_q.delete();
    end else begin
      if (k != 0) begin
        kd = 2'd3;
        for (int i = 3; i >= 0; i--) if (k[i]) kd = 2'(i);
        rd = (m_q.size() > 0) ? m_q[$] : m_dir;
        if (kd == rd || kd == (rd ^ 2'd2)) m_drop = 1;
        else if (m_q.size() == QDEPTH && !t) m_drop = 1;
        else push = 1;
      end
      if (t && m_q.size() > 0) m_dir = m_q.pop_front();
      if (push) m_q.push_back(kd);
      m_step = t;
    end
  endtask

  task automatic apply(input logic [3:0] k, input logic t, input logic c);
    @(negedge clk);
    key_pulse = k;
    tick      = t;
    clr       = c;
    model_step(k, t, c);
    @(posedge clk);
    #1;
    key_pulse = 4'b0;
    tick      = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_pulse = 4'b0; tick = 1'b0; clr = 1'b0;
    m_dir = INIT_DIR; m_step = 0; m_drop = 0; m_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (dir !== 2'd1) begin n_bad++; $display("FAIL reset_dir got=%0d want=1", dir); end
    n_cmp++; if (q_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d want=0", q_count); end
    n_cmp++; if (step !== 1'b0 || drop !== 1'b0) begin n_bad++; $display("FAIL reset_pulses step=%b drop=%b want 0 0", step, drop); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(4'b0, 1'b1, 1'b0);
      n_cmp++; if (step !== 1'b1 || dir !== 2'd1) begin n_bad++; $display("FAIL idle_tick%0d step=%b dir=%0d want 1 1", i, step, dir); end
    end
    apply(4'b0, 1'b0, 1'b0);
    n_cmp++; if (step !== 1'b0) begin n_bad++; $display("FAIL step_falls got=%b want=0", step); end
  endtask

  task automatic test_reversal();
    apply(4'b1000, 1'b0, 1'b0);
    n_cmp++; if (drop !== 1'b1 || q_count !== 2'd0) begin n_bad++; $display("FAIL rev_left drop=%b cnt=%0d want 1 0", drop, q_count); end
    apply(4'b0, 1'b0, 1'b0);
    n_cmp++; if (drop !== 1'b0) begin n_bad++; $display("FAIL rev_drop_pulse got=%b want=0", drop); end
    apply(4'b0010, 1'b0, 1'b0);
    n_cmp++; if (drop !== 1'b1 || q_count !== 2'd0) begin n_bad++; $display("FAIL rev_same drop=%b cnt=%0d want 1 0", drop, q_count); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd1 || drop !== 1'b0) begin n_bad++; $display("FAIL rev_tick dir=%0d drop=%b want 1 0", dir, drop); end
  endtask

  task automatic test_double_tap();
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b1000, 1'b0, 1'b0);
    n_cmp++; if (q_count !== 2'd2 || drop !== 1'b0) begin n_bad++; $display("FAIL dtap_queue cnt=%0d drop=%b want 2 0", q_count, drop); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd0 || q_count !== 2'd1) begin n_bad++; $display("FAIL dtap_tick1 dir=%0d cnt=%0d want 0 1", dir, q_count); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd3 || q_count !== 2'd0) begin n_bad++; $display("FAIL dtap_tick2 dir=%0d cnt=%0d want 3 0", dir, q_count); end
  endtask

  task automatic test_full();
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b1000, 1'b0, 1'b0);
    apply(4'b0100, 1'b0, 1'b0);
    n_cmp++; if (drop !== 1'b1 || q_count !== 2'd2) begin n_bad++; $display("FAIL full_drop drop=%b cnt=%0d want 1 2", drop, q_count); end
    apply(4'b0100, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd0 || q_count !== 2'd2 || drop !== 1'b0) begin n_bad++; $display("FAIL full_tick_push dir=%0d cnt=%0d drop=%b want 0 2 0", dir, q_count, drop); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd3) begin n_bad++; $display("FAIL full_drain1 dir=%0d want 3", dir); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd2 || q_count !== 2'd0) begin n_bad++; $display("FAIL full_drain2 dir=%0d cnt=%0d want 2 0", dir, q_count); end
  endtask

  task automatic test_simul_keys();
    apply(4'b1000, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd2 || q_count !== 2'd1) begin n_bad++; $display("FAIL nobypass dir=%0d cnt=%0d want 2 1", dir, q_count); end
    apply(4'b0001, 1'b1, 1'b0);
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd0 || q_count !== 2'd0) begin n_bad++; $display("FAIL simul_setup dir=%0d cnt=%0d want 0 0", dir, q_count); end
    apply(4'b1010, 1'b0, 1'b0);
    n_cmp++; if (drop !== 1'b0 || q_count !== 2'd1) begin n_bad++; $display("FAIL simul_keys drop=%b cnt=%0d want 0 1", drop, q_count); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd1) begin n_bad++; $display("FAIL simul_pick dir=%0d want 1", dir); end
  endtask

  task automatic test_clr();
    apply(4'b0001, 1'b1, 1'b0);
    apply(4'b1000, 1'b1, 1'b0);
    apply(4'b0, 1'b1, 1'b0);
    apply(4'b0100, 1'b0, 1'b0);
    n_cmp++; if (dir !== 2'd3 || q_count !== 2'd1) begin n_bad++; $display("FAIL clr_setup dir=%0d cnt=%0d want 3 1", dir, q_count); end
    apply(4'b0001, 1'b1, 1'b1);
    n_cmp++; if (dir !== 2'd1 || q_count !== 2'd0 || step !== 1'b0 || drop !== 1'b0)
      begin n_bad++; $display("FAIL clr_apply dir=%0d cnt=%0d step=%b drop=%b want 1 0 0 0", dir, q_count, step, drop); end
    apply(4'b0, 1'b1, 1'b0);
    n_cmp++; if (dir !== 2'd1 || step !== 1'b1) begin n_bad++; $display("FAIL clr_after dir=%0d step=%b want 1 1", dir, step); end
  endtask

  task automatic test_random();
    logic [3:0] k;
    logic       t;
    logic       c;
    int         r;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) k = 4'b0;
      else if (r < 8) k = 4'(1 << $urandom_range(0, 3));
      else k = 4'($urandom_range(1, 15));
      t = ($urandom_range(0, 9) < 3);
      c = ($urandom_range(0, 49) == 0);
      apply(k, t, c);
      n_cmp++;
      if (dir !== m_dir || step !== m_step || drop !== m_drop || q_count !== CW'(m_q.size())) begin
        n_bad++;
        $display("FAIL rand_cycle%0d dir=%0d step=%b drop=%b cnt=%0d want %0d %b %b %0d",
                 n, dir, step, drop, q_count, m_dir, m_step, m_drop, m_q.size());
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_reversal();
    test_double_tap();
    test_full();
    test_simul_keys();
    test_clr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
